// File: rtl/pdeintlv_pkg.sv
// pdeintlv_pkg: shared defaults, FSM encodings and the derived helper for the
// payload de-interleaver.
package pdeintlv_pkg;

    localparam int DEF_LLR_W  = 6;
    localparam int DEF_N_CBPS = 192;
    localparam int DEF_N_BPSC = 4;
    localparam int ADDR_W     = $clog2(DEF_N_CBPS);

    // write-side FSM
    localparam logic [1:0] WR_FILL = 2'd0;
    localparam logic [1:0] WR_WAIT = 2'd1;
    localparam logic [1:0] WR_PAD  = 2'd2;

    // read-side FSM
    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_RUN  = 1'b1;

    // s = max(N_BPSC/2, 1): bits per constellation axis
    function automatic int bits_per_axis(input int n_bpsc);
        return (n_bpsc / 2 > 1) ? n_bpsc / 2 : 1;
    endfunction

endpackage

// File: rtl/pdeintlv_addr.sv
// pdeintlv_addr: combinational j -> k address map for the de-interleaver.
// Applies the second-permutation inverse (i) then the first (k) arithmetically.
module pdeintlv_addr
    import pdeintlv_pkg::*;
#(
    parameter int N_CBPS = DEF_N_CBPS,
    parameter int N_BPSC = DEF_N_BPSC,
    parameter int AW     = $clog2(N_CBPS)
) (
    input  logic [AW-1:0] j_i,
    output logic [AW-1:0] k_o
);
    localparam int S  = bits_per_axis(N_BPSC);
    // wide enough for 16*(N_CBPS-1)
    localparam int XW = AW + 5;

    logic [XW-1:0] j_x;
    logic [XW-1:0] f_j;
    logic [XW-1:0] i_x;
    logic [XW-1:0] f_i;

    // i = s*floor(j/s) + (j + floor(16j/N)) mod s ; k = 16i - (N-1)*floor(16i/N)
    always_comb begin
        j_x = XW'(j_i);
        f_j = (j_x << 4) / XW'(N_CBPS);
        i_x = XW'(S) * (j_x / XW'(S)) + (j_x + f_j) % XW'(S);
        f_i = (i_x << 4) / XW'(N_CBPS);
        k_o = AW'((i_x << 4) - XW'(N_CBPS - 1) * f_i);
    end

endmodule

// File: rtl/pdeintlv.sv
// pdeintlv: ping-pong payload de-interleaver between the 16QAM demapper and
// the Viterbi decoder. Optional flush/erasure padding under PDEINTLV_FLUSH_EN.
module pdeintlv
    import pdeintlv_pkg::*;
#(
    parameter int LLR_W  = DEF_LLR_W,
    parameter int N_CBPS = DEF_N_CBPS,
    parameter int N_BPSC = DEF_N_BPSC
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef PDEINTLV_FLUSH_EN
    input  logic                    flush_i,
`endif
    input  logic signed [LLR_W-1:0] di_i,
    input  logic                    di_vld_i,
    input  logic                    do_rdy_i,
    output logic signed [LLR_W-1:0] do_o,
    output logic                    do_vld_o,
    output logic                    do_sop_o,
    output logic                    ovf_o
);
    localparam int            AW   = $clog2(N_CBPS);
    localparam logic [AW-1:0] LAST = AW'(N_CBPS - 1);

    logic signed [LLR_W-1:0] mem [2][N_CBPS];

    logic [1:0]    wr_st_q, wr_st_d;
    logic [0:0]    rd_st_q, rd_st_d;
    logic [AW-1:0] j_q, j_d, ra_q, ra_d, k;
    logic          wbank_q, wbank_d, rbank_q, rbank_d;
    logic          ovf_q, ovf_d;

    logic signed [LLR_W-1:0] ram_q, do_q;
    logic          ram_vld_q, ram_sop_q, do_vld_q, do_sop_q;

    logic          adv, issue, rd_last, rd_free;
    logic          flush_take, pad, wr_en, wr_last, swap, drop;
    logic signed [LLR_W-1:0] wr_data;

    pdeintlv_addr #(.N_CBPS(N_CBPS), .N_BPSC(N_BPSC), .AW(AW)) u_addr (
        .j_i (j_q),
        .k_o (k)
    );

    // handshake, bank hand-over and write/read FSM next state
    always_comb begin
        // output register empty or being taken: whole read pipe may move
        adv     = !do_vld_q || do_rdy_i;
        issue   = (rd_st_q == RD_RUN) && adv;
        rd_last = issue && (ra_q == LAST);
        // a bank is free once its last address is fetched; the tail drains
        // from the pipe registers so back-to-back symbols never stall
        rd_free = (rd_st_q == RD_IDLE) || rd_last;
`ifdef PDEINTLV_FLUSH_EN
        flush_take = (wr_st_q == WR_FILL) && flush_i && (j_q != '0);
        pad        = (wr_st_q == WR_PAD);
`else
        flush_take = 1'b0;
        pad        = 1'b0;
`endif
        wr_en   = ((wr_st_q == WR_FILL) && di_vld_i && !flush_take) || pad;
        wr_data = pad ? '0 : di_i;
        wr_last = wr_en && (j_q == LAST);
        swap    = (wr_last || (wr_st_q == WR_WAIT)) && rd_free;
        // anything not taken by the fill path is lost (WAIT, PAD, flush cycle)
        drop    = di_vld_i && !((wr_st_q == WR_FILL) && !flush_take);

        wr_st_d = wr_st_q;
        rd_st_d = rd_st_q;
        j_d     = j_q;
        ra_d    = ra_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        ovf_d   = ovf_q || drop;

        if (flush_take) wr_st_d = WR_PAD;
        if (wr_en)      j_d = wr_last ? '0 : j_q + AW'(1);
        if (wr_last)    wr_st_d = rd_free ? WR_FILL : WR_WAIT;
        if ((wr_st_q == WR_WAIT) && rd_free) wr_st_d = WR_FILL;

        if (issue)   ra_d = rd_last ? '0 : ra_q + AW'(1);
        if (rd_last) rd_st_d = RD_IDLE;
        if (swap) begin
            wbank_d = ~wbank_q;
            rbank_d = ~rbank_q;
            rd_st_d = RD_RUN;
            ra_d    = '0;
        end
    end

    // bank write at the permuted address (contents never reset)
    always_ff @(posedge clk) begin
        if (wr_en) mem[wbank_q][k] <= wr_data;
    end

    // synchronous bank read; held while the pipe is stalled
    always_ff @(posedge clk) begin
        if (issue) ram_q <= mem[rbank_q][ra_q];
    end

    // control state and the two-stage read pipe (RAM stage, output stage)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_st_q   <= WR_FILL;
            rd_st_q   <= RD_IDLE;
            j_q       <= '0;
            ra_q      <= '0;
            wbank_q   <= 1'b0;
            rbank_q   <= 1'b1;
            ovf_q     <= 1'b0;
            ram_vld_q <= 1'b0;
            ram_sop_q <= 1'b0;
            do_q      <= '0;
            do_vld_q  <= 1'b0;
            do_sop_q  <= 1'b0;
        end else begin
            wr_st_q <= wr_st_d;
            rd_st_q <= rd_st_d;
            j_q     <= j_d;
            ra_q    <= ra_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            ovf_q   <= ovf_d;
            if (adv) begin
                ram_vld_q <= issue;
                ram_sop_q <= issue && (ra_q == '0);
                do_vld_q  <= ram_vld_q;
                do_sop_q  <= ram_sop_q;
                if (ram_vld_q) do_q <= ram_q;
            end
        end
    end

    assign do_o     = do_q;
    assign do_vld_o = do_vld_q;
    assign do_sop_o = do_sop_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_pdeintlv.sv
// tb_pdeintlv: directed bench for the payload de-interleaver.
// Flush test is compiled in only with PDEINTLV_FLUSH_EN.
`timescale 1ns/1ps
module tb_pdeintlv;
    import pdeintlv_pkg::*;

    localparam int W = DEF_LLR_W;
    localparam int N = DEF_N_CBPS;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [W-1:0] di_i;
    logic                di_vld_i;
    logic                do_rdy_i;
    logic signed [W-1:0] do_o;
    logic                do_vld_o;
    logic                do_sop_o;
    logic                ovf_o;
`ifdef PDEINTLV_FLUSH_EN
    logic                flush_i;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int c0;
    int first_out, last_out;
    int inv [N];

    logic [W-1:0] out_q [$];
    logic [W-1:0] exp_q [$];
    bit           sop_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pdeintlv dut (
        .clk      (clk),
        .rst      (rst),
`ifdef PDEINTLV_FLUSH_EN
        .flush_i  (flush_i),
`endif
        .di_i     (di_i),
        .di_vld_i (di_vld_i),
        .do_rdy_i (do_rdy_i),
        .do_o     (do_o),
        .do_vld_o (do_vld_o),
        .do_sop_o (do_sop_o),
        .ovf_o    (ovf_o)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    // 802.11a de-interleave address for 16QAM (s = 2)
    function automatic int kmap(input int j);
        int i;
        i = 2 * (j / 2) + (j + (16 * j) / N) % 2;
        return 16 * i - (N - 1) * ((16 * i) / N);
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] d);
        di_vld_i = v;
        di_i     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit chk_en);
        rst      = 1'b1;
        di_vld_i = 1'b0;
        di_i     = '0;
        do_rdy_i = 1'b1;
`ifdef PDEINTLV_FLUSH_EN
        flush_i  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        if (chk_en) begin
            chk("rst_do",  longint'($unsigned(do_o)), 0);
            chk("rst_vld", longint'(do_vld_o), 0);
            chk("rst_sop", longint'(do_sop_o), 0);
            chk("rst_ovf", longint'(ovf_o), 0);
        end
        rst = 1'b0;
        out_q.delete();
        sop_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_out(input int n, input int budget);
        int c = 0;
        while (out_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_stream(input string tag);
        int bad  = 0;
        int sbad = 0;
        chk({tag, "_cnt"}, out_q.size(), exp_q.size());
        for (int p = 0; p < exp_q.size() && p < out_q.size(); p++) begin
            if (out_q[p] !== exp_q[p]) bad++;
            if (sop_q[p] != (p % N == 0)) sbad++;
        end
        chk({tag, "_data"}, bad, 0);
        chk({tag, "_sop"}, sbad, 0);
    endtask

    // output monitor: collect accepted LLRs, check hold-while-stalled
    initial begin
        bit           prev_stall = 1'b0;
        logic [W-1:0] prev_do    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_vld", longint'(do_vld_o), 1);
                    chk("hold_do", longint'($unsigned(do_o)), longint'(prev_do));
                end
                if (do_vld_o && do_rdy_i) begin
                    if (out_q.size() == 0) first_out = cyc;
                    last_out = cyc;
                    out_q.push_back(do_o);
                    sop_q.push_back(do_sop_o);
                end
                prev_stall = do_vld_o && !do_rdy_i;
                prev_do    = do_o;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        di_vld_i = 1'b0;
        di_i     = '0;
        do_rdy_i = 1'b1;
`ifdef PDEINTLV_FLUSH_EN
        flush_i  = 1'b0;
`endif
        for (int j = 0; j < N; j++) inv[kmap(j)] = j;

        // reset state
        do_reset(1'b1);

        // address map and latency: di = j
        for (int p = 0; p < N; p++) exp_q.push_back(W'(inv[p]));
        c0 = cyc;
        for (int j = 0; j < N; j++) drive(1'b1, W'(j));
        drive(1'b0, '0);
        wait_out(N, 600);
        cmp_stream("map");
        chk("map_p0",  longint'(out_q[0]),  0);
        chk("map_p1",  longint'(out_q[1]),  13);
        chk("map_p2",  longint'(out_q[2]),  24);
        chk("map_p3",  longint'(out_q[3]),  37);
        chk("map_p16", longint'(out_q[16]), 1);
        chk("map_p17", longint'(out_q[17]), 12);
        chk("lat_first", first_out - c0, 194);
        chk("lat_last",  last_out - c0, 385);
        chk("map_ovf", longint'(ovf_o), 0);

        // four back-to-back symbols
        do_reset(1'b0);
        for (int s = 0; s < 4; s++)
            for (int p = 0; p < N; p++) exp_q.push_back(W'(inv[p] + 3 * s));
        for (int s = 0; s < 4; s++)
            for (int j = 0; j < N; j++) drive(1'b1, W'(j + 3 * s));
        drive(1'b0, '0);
        wait_out(4 * N, 800);
        cmp_stream("cont");
        chk("cont_ovf", longint'(ovf_o), 0);

        // backpressure: long stall while the next symbols stream in
        do_reset(1'b0);
        for (int s = 0; s < 3; s++)
            for (int p = 0; p < N; p++) exp_q.push_back(W'(inv[p] * 5 + s));
        fork
            begin
                for (int s = 0; s < 4; s++)
                    for (int j = 0; j < N; j++) drive(1'b1, W'(j * 5 + s));
                drive(1'b0, '0);
            end
            begin
                repeat (450) @(posedge clk);
                #1;
                do_rdy_i = 1'b0;
                repeat (300) @(posedge clk);
                #1;
                do_rdy_i = 1'b1;
            end
        join
        wait_out(3 * N, 1500);
        cmp_stream("bp");
        chk("bp_ovf", longint'(ovf_o), 1);

        // reset in the middle of a symbol, then one full symbol
        do_reset(1'b0);
        for (int j = 0; j < 100; j++) drive(1'b1, W'(17));
        do_reset(1'b1);
        for (int p = 0; p < N; p++) exp_q.push_back(W'(inv[p] + 5));
        for (int j = 0; j < N; j++) drive(1'b1, W'(j + 5));
        drive(1'b0, '0);
        wait_out(N, 600);
        cmp_stream("mid_rst");

`ifdef PDEINTLV_FLUSH_EN
        // partial symbol padded with erasures
        do_reset(1'b0);
        for (int p = 0; p < N; p++) exp_q.push_back((inv[p] < 100) ? W'(5) : W'(0));
        for (int j = 0; j < 100; j++) drive(1'b1, W'(5));
        flush_i = 1'b1;
        drive(1'b0, '0);
        flush_i = 1'b0;
        wait_out(N, 800);
        cmp_stream("flush");
        chk("flush_ovf", longint'(ovf_o), 0);
        // flush on an empty symbol does nothing
        flush_i = 1'b1;
        drive(1'b0, '0);
        flush_i = 1'b0;
        repeat (300) drive(1'b0, '0);
        chk("flush_j0", out_q.size(), N);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
